// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the clock datapath counters.
package clock_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned MAX_W      = BCD_W * MAX_DIGITS;

  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  localparam int unsigned HOUR12_MIN = 1;
  localparam int unsigned HOUR12_MAX = 12;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return digit <= BCD_NINE;
  endfunction

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Most significant digit first; digits above the used count are ignored.
  function automatic int unsigned bcd_to_bin(input logic [MAX_W-1:0] value,
                                             input int unsigned digits);
    int unsigned r = 0;
    int unsigned idx;
    for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
      idx = MAX_DIGITS - 1 - k;
      if (idx < digits) r = r * 10 + 32'(value[idx*BCD_W +: BCD_W]);
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] bin_to_bcd(input int unsigned value,
                                                  input int unsigned digits);
    logic [MAX_W-1:0] r = '0;
    int unsigned v = value;
    for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
      if (k < digits) r[k*BCD_W +: BCD_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/data bundle between a counter stage and whatever drives it.
interface bcd_mod_counter_if import clock_pkg::*; #(
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned QW = BCD_W * DIGITS;

  logic          EN;
  logic          UP;
  logic          LD;
  logic [QW-1:0] D;
  logic          MODE12;
  logic [QW-1:0] Q;
  logic          CO;
  logic          LD_ERR;

  modport master (output EN, UP, LD, D, MODE12, input Q, CO, LD_ERR);
  modport slave  (input EN, UP, LD, D, MODE12, output Q, CO, LD_ERR);

endinterface

// File: rtl/bcd_digit.sv
// Single BCD digit step: +1/-1 when carry/borrow arrives, wrapping 9<->0.
module bcd_digit import clock_pkg::*; (
  input  logic [BCD_W-1:0] digit,
  input  logic             up,
  input  logic             cin,
  output logic [BCD_W-1:0] next_c,
  output logic             cout_c,
  output logic             term_c
);

  always_comb begin
    term_c = up ? (digit == BCD_NINE) : (digit == BCD_ZERO);
    cout_c = cin & term_c;
    next_c = digit;
    if (cin) begin
      if (term_c) next_c = up ? BCD_ZERO : BCD_NINE;
      else        next_c = up ? digit + 4'd1 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter with up/down, validated preset load,
// optional 12-hour range and a combinational cascade carry/borrow.
module bcd_mod_counter import clock_pkg::*; #(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned MODULUS   = 60,
  parameter int unsigned HOUR12_EN = 0
) (
  input logic              CP,
  input logic              CR,
  bcd_mod_counter_if.slave bus
);

  localparam int unsigned QW = BCD_W * DIGITS;
  localparam logic [QW-1:0] NORM_MAX_BCD = QW'(bin_to_bcd(MODULUS - 1, DIGITS));
  localparam logic [QW-1:0] H12_MIN_BCD  = QW'(HOUR12_MIN);
  localparam logic [QW-1:0] H12_MAX_BCD  = QW'(bin_to_bcd(HOUR12_MAX, DIGITS));

  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("bcd_mod_counter: DIGITS must be 1..4");
  end
  if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
    $error("bcd_mod_counter: MODULUS must be 2..10^DIGITS");
  end
  if (HOUR12_EN != 0 && DIGITS < 2) begin : g_bad_hour12
    $error("bcd_mod_counter: HOUR12_EN needs DIGITS >= 2");
  end

  logic              mode12;
  logic [QW-1:0]     min_bcd;
  logic [QW-1:0]     max_bcd;
  int unsigned       min_bin;
  int unsigned       max_bin;
  int unsigned       q_bin;
  int unsigned       d_bin;
  logic              q_in_range;
  logic              at_min;
  logic              at_max;
  logic [DIGITS-1:0] d_digits_ok;
  logic              d_ok;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] term;
  logic [QW-1:0]     step_c;
  logic [QW-1:0]     q_r;
  logic [QW-1:0]     q_next;
  logic              ld_err_r;
  logic              ld_err_next;
  logic              unused_chain;

  // Active range bounds, kept in both BCD (for muxing) and binary (for compares).
  assign mode12  = (HOUR12_EN != 0) && bus.MODE12;
  assign min_bcd = mode12 ? H12_MIN_BCD : '0;
  assign max_bcd = mode12 ? H12_MAX_BCD : NORM_MAX_BCD;
  assign min_bin = mode12 ? HOUR12_MIN : 32'd0;
  assign max_bin = mode12 ? HOUR12_MAX : MODULUS - 1;

  assign q_bin      = bcd_to_bin(MAX_W'(q_r), DIGITS);
  assign q_in_range = (q_bin >= min_bin) && (q_bin <= max_bin);
  assign at_min     = q_in_range && (q_r == min_bcd);
  assign at_max     = (q_r == max_bcd);

  assign d_bin = bcd_to_bin(MAX_W'(bus.D), DIGITS);
  assign d_ok  = (&d_digits_ok) && (d_bin >= min_bin) && (d_bin <= max_bin);

  // Ripple carry/borrow chain; digit 0 always steps.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign d_digits_ok[i] = bcd_valid(bus.D[i*BCD_W +: BCD_W]);

    bcd_digit u_digit (
      .digit  (q_r[i*BCD_W +: BCD_W]),
      .up     (bus.UP),
      .cin    (carry[i]),
      .next_c (step_c[i*BCD_W +: BCD_W]),
      .cout_c (carry[i+1]),
      .term_c (term[i])
    );
  end

  // Whole-chain overflow is superseded by the explicit MIN/MAX wrap below.
  assign unused_chain = carry[DIGITS] ^ (^term);

  // Load beats count; out-of-range Q snaps to MIN on the next enabled count.
  always_comb begin
    q_next      = q_r;
    ld_err_next = ld_err_r;
    if (bus.LD) begin
      if (d_ok) begin
        q_next      = bus.D;
        ld_err_next = 1'b0;
      end else begin
        ld_err_next = 1'b1;
      end
    end else if (bus.EN) begin
      if (!q_in_range || (bus.UP && at_max)) q_next = min_bcd;
      else if (!bus.UP && at_min)            q_next = max_bcd;
      else                                   q_next = step_c;
    end
  end

  always_ff @(negedge CP) begin
    if (CR) begin
      q_r      <= min_bcd;
      ld_err_r <= 1'b0;
    end else begin
      q_r      <= q_next;
      ld_err_r <= ld_err_next;
    end
  end

  assign bus.Q      = q_r;
  assign bus.LD_ERR = ld_err_r;
  assign bus.CO     = bus.EN & ~CR & ~bus.LD & (bus.UP ? at_max : at_min);

endmodule
